// File: rtl/uart_recv_pkg.sv
// Shared definitions for the 8N1 UART receiver: line levels, default bit period and
// receiver state encoding.
package uart_recv_pkg;

    localparam logic START_BIT            = 1'b0;
    localparam logic STOP_BIT             = 1'b1;
    localparam int   DEFAULT_CLKS_PER_BIT = 26;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RXD pin, plus a one-cycle-delayed copy
// used to detect the falling edge that marks a start bit.
module uart_rx_sync (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q,
    output logic FALL
);

    logic       meta;
    logic       rx_s;
    logic       rx_q;
    logic [2:0] vld;

    always_ff @(posedge CLK) begin
        if (RST) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
            rx_q <= 1'b1;
            vld  <= '0;
        end else begin
            meta <= D;
            rx_s <= meta;
            rx_q <= rx_s;
            vld  <= {vld[1:0], 1'b1};
        end
    end

    // The reset-value ones must flush out before an edge counts, otherwise a line
    // held low through reset would look like a fresh start bit.
    assign Q    = rx_s;
    assign FALL = vld[2] & rx_q & ~rx_s;

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver: mid-bit sampling off a down-counter, LSB-first shift register,
// level-valid/ack output with framing-error pulse and sticky overrun.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a falling edge on the synchronized line
// ST_START | counting to mid start bit; line high there is a glitch
// ST_DATA  | sampling 8 data bits, one per bit period
// ST_STOP  | sampling the stop bit, then back to idle at mid-stop
module uart_recv
    import uart_recv_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] DATA,
    output logic       DATA_VALID,
    input  logic       DATA_ACK,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       BUSY
);

    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic [7:0]       data_r;
    logic             dv_r;
    logic             ov_r;
    logic             fe_r;
    logic             busy_r;
    logic             rx_s;
    logic             rx_fall;
    logic             sample;
    logic             shift_en;
    logic             byte_done;
    logic             frame_bad;
    logic             ack_ok;

    uart_rx_sync u_sync (
        .CLK  (CLK),
        .RST  (RST),
        .D    (RXD),
        .Q    (rx_s),
        .FALL (rx_fall)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (rx_fall) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (sample) begin
                    state_nxt = (rx_s == START_BIT) ? ST_DATA : ST_IDLE;
                end
            end
            ST_DATA: begin
                if (sample && (bit_idx == 3'd7)) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leaving at mid-stop gives half a bit of slack to catch the next start edge.
                if (sample) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sample    = (cnt == '0);
        shift_en  = (state == ST_DATA) && sample;
        byte_done = (state == ST_STOP) && sample && (rx_s == STOP_BIT);
        frame_bad = (state == ST_STOP) && sample && (rx_s != STOP_BIT);
        ack_ok    = DATA_ACK && dv_r;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt     <= HALF_RELOAD;
            bit_idx <= '0;
            shreg   <= '0;
            data_r  <= '0;
            dv_r    <= 1'b0;
            ov_r    <= 1'b0;
            fe_r    <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            busy_r <= (state_nxt != ST_IDLE);
            fe_r   <= frame_bad;

            if (state == ST_IDLE) begin
                cnt <= HALF_RELOAD;
            end else if (sample) begin
                cnt <= BIT_RELOAD;
            end else begin
                cnt <= cnt - 1'b1;
            end

            if ((state == ST_START) && sample) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end

            if (shift_en) begin
                shreg <= {rx_s, shreg[7:1]};
            end

            if (byte_done) begin
                data_r <= shreg;
                dv_r   <= 1'b1;
                if (dv_r && !DATA_ACK) begin
                    ov_r <= 1'b1;
                end else if (ack_ok) begin
                    ov_r <= 1'b0;
                end
            end else if (ack_ok) begin
                dv_r <= 1'b0;
                ov_r <= 1'b0;
            end
        end
    end

    assign DATA       = data_r;
    assign DATA_VALID = dv_r;
    assign FRAME_ERR  = fe_r;
    assign OVERRUN    = ov_r;
    assign BUSY       = busy_r;

endmodule

// File: tb/tb_uart_recv.sv
// Scoreboard bench for uart_recv: a bit-banged 8N1 transmitter drives RXD and every
// byte it sends is queued for comparison against what the receiver presents.
module tb_uart_recv;

    localparam int CPB = 26;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RXD = 1'b1;
    logic       DATA_ACK = 1'b0;
    logic [7:0] DATA;
    logic       DATA_VALID;
    logic       FRAME_ERR;
    logic       OVERRUN;
    logic       BUSY;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tx_fall_cyc = 0;
    int dv_rise_cyc = 0;
    int fe_cnt = 0;
    int busy_cnt = 0;
    logic dv_prev = 1'b0;
    logic [7:0] exp_q[$];

    uart_recv #(.CLKS_PER_BIT(CPB), .CNT_W(5)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RXD        (RXD),
        .DATA       (DATA),
        .DATA_VALID (DATA_VALID),
        .DATA_ACK   (DATA_ACK),
        .FRAME_ERR  (FRAME_ERR),
        .OVERRUN    (OVERRUN),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (DATA_VALID && !dv_prev) dv_rise_cyc = cyc;
        dv_prev = DATA_VALID;
        if (FRAME_ERR) fe_cnt = fe_cnt + 1;
        if (BUSY) busy_cnt = busy_cnt + 1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Starts immediately; caller is positioned just after a rising edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        RXD = 1'b0;
        tx_fall_cyc = cyc;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            wait_cyc(CPB);
        end
        RXD = stop_v;
        wait_cyc(CPB);
    endtask

    task automatic pulse_ack();
        DATA_ACK = 1'b1;
        wait_cyc(1);
        DATA_ACK = 1'b0;
    endtask

    task automatic wait_dv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (DATA_VALID === 1'b1) begin
                ok = 1'b1;
                break;
            end
            wait_cyc(1);
        end
    endtask

    task automatic test_reset();
        int bad;
        RST = 1'b1;
        RXD = 1'b1;
        wait_cyc(3);
        RST = 1'b0;
        wait_cyc(1);
        checks++;
        if ({DATA, DATA_VALID, FRAME_ERR, OVERRUN, BUSY} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got %h expected 000", {DATA, DATA_VALID, FRAME_ERR, OVERRUN, BUSY});
        end
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            wait_cyc(1);
            if ({DATA, DATA_VALID, FRAME_ERR, OVERRUN, BUSY} !== 12'h000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_quiet got %0d nonzero cycles expected 0", bad);
        end
    endtask

    task automatic test_single_byte();
        bit ok;
        logic [7:0] exp;
        int lat;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_dv(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL a5_valid got timeout expected DATA_VALID");
        end
        exp = exp_q.pop_front();
        checks++;
        if (DATA !== exp) begin
            errors++;
            $display("FAIL a5_data got %h expected %h", DATA, exp);
        end
        lat = dv_rise_cyc - tx_fall_cyc;
        checks++;
        if (lat < 249 || lat > 251) begin
            errors++;
            $display("FAIL a5_latency got %0d expected 250+/-1", lat);
        end
        wait_cyc(5);
        pulse_ack();
        checks++;
        if (DATA_VALID !== 1'b0 || DATA !== 8'hA5) begin
            errors++;
            $display("FAIL a5_ack got dv=%b data=%h expected dv=0 data=a5", DATA_VALID, DATA);
        end
    endtask

    task automatic test_glitch();
        int b0, f0;
        b0 = busy_cnt;
        f0 = fe_cnt;
        RXD = 1'b0;
        wait_cyc(8);
        RXD = 1'b1;
        wait_cyc(40);
        checks++;
        if (busy_cnt - b0 != 13) begin
            errors++;
            $display("FAIL glitch_busy got %0d busy cycles expected 13", busy_cnt - b0);
        end
        checks++;
        if (DATA_VALID !== 1'b0 || fe_cnt != f0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL glitch_quiet got dv=%b fe=%0d busy=%b expected 0 0 0", DATA_VALID, fe_cnt - f0, BUSY);
        end
    endtask

    task automatic test_frame_err();
        int f0;
        bit ok;
        logic [7:0] exp;
        f0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        RXD = 1'b1;
        wait_cyc(2);
        checks++;
        if (fe_cnt - f0 != 1) begin
            errors++;
            $display("FAIL ferr_pulse got %0d cycles expected 1", fe_cnt - f0);
        end
        checks++;
        if (DATA_VALID !== 1'b0 || DATA !== 8'hA5) begin
            errors++;
            $display("FAIL ferr_hold got dv=%b data=%h expected dv=0 data=a5", DATA_VALID, DATA);
        end
        wait_cyc(30);
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1);
        wait_dv(ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok || DATA !== exp) begin
            errors++;
            $display("FAIL ferr_recover got ok=%b data=%h expected ok=1 data=%h", ok, DATA, exp);
        end
        pulse_ack();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        exp = exp_q.pop_back();
        exp_q.delete();
        checks++;
        if (OVERRUN !== 1'b1 || DATA_VALID !== 1'b1 || DATA !== exp) begin
            errors++;
            $display("FAIL b2b_overrun got ov=%b dv=%b data=%h expected ov=1 dv=1 data=%h", OVERRUN, DATA_VALID, DATA, exp);
        end
        pulse_ack();
        checks++;
        if (OVERRUN !== 1'b0 || DATA_VALID !== 1'b0 || DATA !== exp) begin
            errors++;
            $display("FAIL b2b_ack got ov=%b dv=%b data=%h expected ov=0 dv=0 data=%h", OVERRUN, DATA_VALID, DATA, exp);
        end
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        checks++;
        if (OVERRUN !== 1'b1) begin
            errors++;
            $display("FAIL b2b_overrun2 got %b expected 1", OVERRUN);
        end
        exp_q.push_back(8'h5A);
        fork
            send_frame(8'h5A, 1'b1);
            begin
                wait_cyc(249);
                pulse_ack();
            end
        join
        exp = exp_q.pop_front();
        checks++;
        if (OVERRUN !== 1'b0 || DATA_VALID !== 1'b1 || DATA !== exp) begin
            errors++;
            $display("FAIL ack_with_byte got ov=%b dv=%b data=%h expected ov=0 dv=1 data=%h", OVERRUN, DATA_VALID, DATA, exp);
        end
        pulse_ack();
    endtask

    task automatic test_loopback();
        bit ok;
        logic [7:0] exp;
        logic [7:0] b;
        int f0, bad;
        f0 = fe_cnt;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            if (b == 8'h40) begin
                fork
                    send_frame(b, 1'b1);
                    begin
                        wait_cyc(CPB * 8 + CPB / 2);
                        RST = 1'b1;
                        wait_cyc(1);
                        checks++;
                        if ({DATA, DATA_VALID, FRAME_ERR, OVERRUN, BUSY} !== 12'h000) begin
                            errors++;
                            $display("FAIL midframe_reset got %h expected 000", {DATA, DATA_VALID, FRAME_ERR, OVERRUN, BUSY});
                        end
                        RST = 1'b0;
                    end
                join
            end else begin
                exp_q.push_back(b);
                send_frame(b, 1'b1);
                wait_dv(ok);
                if (!ok) begin
                    checks++;
                    errors++;
                    $display("FAIL loop_timeout got no DATA_VALID expected byte %h", b);
                end else begin
                    exp = exp_q.pop_front();
                    checks++;
                    if (DATA !== exp) begin
                        errors++;
                        $display("FAIL loop_data got %h expected %h", DATA, exp);
                    end
                    wait_cyc($urandom_range(0, 20));
                    pulse_ack();
                    if (DATA_VALID !== 1'b0) bad++;
                end
            end
        end
        wait_cyc(20);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL loop_ack got %0d stuck valids expected 0", bad);
        end
        checks++;
        if (exp_q.size() != 0 || fe_cnt != f0 || OVERRUN !== 1'b0 || DATA_VALID !== 1'b0) begin
            errors++;
            $display("FAIL loop_end got q=%0d fe=%0d ov=%b dv=%b expected 0 0 0 0", exp_q.size(), fe_cnt - f0, OVERRUN, DATA_VALID);
        end
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        wait_cyc(1);
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
